// File: rtl/audio_pkg.sv
// Shared constants, sample type and channel-mix helper for the I2S transmitter.
package audio_pkg;

    localparam int FRAME_BITS = 64;
    localparam int HALF_BITS  = 32;
    localparam int SAMPLE_W   = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Average of two sign-extended samples, rounded toward minus infinity.
    // Operands are pre-extended to 32 bits, so any sample width up to 31
    // fits and the 33-bit sum cannot overflow.
    function automatic logic signed [31:0] mix_avg(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
        logic signed [32:0] sum;
        sum = {a[31], a} + {b[31], b};
        return sum[32:1];
    endfunction

endpackage

// File: rtl/audio_clk_div.sv
// Divide-by-2*DIV clock generator with a one-clk pulse marking its falling toggle.
module audio_clk_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic clk_out,
    output logic fall
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic          tc;

    assign tc   = (cnt == CW'(DIV - 1));
    // High during the clk cycle whose closing edge takes clk_out from 1 to 0.
    assign fall = tc && clk_out;

    // Half-period counter; clk_out flips on every terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (tc) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
        end else begin
            cnt     <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S master transmitter: generates XCK/BCLK/LRCK and shifts out 16-bit
// left/right samples (swap, mix and mute applied at capture time).
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int XCK_DIV     = 1,
    parameter int BCLK_DIV    = 4,
    parameter int SAMPLE_BITS = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SAMPLE_BITS-1:0] ldata,
    input  logic [SAMPLE_BITS-1:0] rdata,
    input  logic                   exchan,
    input  logic                   mix,
    input  logic                   mute,
    output logic                   sample_strobe,
    output logic                   aud_xck,
    output logic                   aud_bclk,
    output logic                   aud_daclrck,
    output logic                   aud_dacdat
);

    localparam int BW = $clog2(FRAME_BITS);
    localparam int HW = $clog2(HALF_BITS);

    logic                   xck_fall;
    logic                   bclk_fall;
    logic [BW-1:0]          bitcnt;
    logic [BW-1:0]          bitcnt_nxt;
    logic [HW-1:0]          h_nxt;
    logic                   capture;
    logic [SAMPLE_BITS-1:0] sh_l;
    logic [SAMPLE_BITS-1:0] sh_r;
    logic [SAMPLE_BITS-1:0] swap_l;
    logic [SAMPLE_BITS-1:0] swap_r;
    logic [SAMPLE_BITS-1:0] proc_l;
    logic [SAMPLE_BITS-1:0] proc_r;
    logic [31:0]            ext_l;
    logic [31:0]            ext_r;
    logic [31:0]            avg;

    // Codec master clock; free-running and unrelated to the serial framing.
    audio_clk_div #(.DIV(XCK_DIV)) u_xck_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_out (aud_xck),
        .fall    (xck_fall)
    );

    // Bit clock; its falling toggle is the only moment serial state advances.
    audio_clk_div #(.DIV(BCLK_DIV)) u_bclk_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_out (aud_bclk),
        .fall    (bclk_fall)
    );

    assign bitcnt_nxt = bitcnt + 1'b1;
    assign h_nxt      = bitcnt_nxt[HW-1:0];
    assign capture    = bclk_fall && (bitcnt == BW'(FRAME_BITS - 1));

    // Sample conditioning: swap, then optional average, then mute on top.
    always_comb begin
        swap_l = exchan ? rdata : ldata;
        swap_r = exchan ? ldata : rdata;
        ext_l  = {{(32 - SAMPLE_BITS){swap_l[SAMPLE_BITS-1]}}, swap_l};
        ext_r  = {{(32 - SAMPLE_BITS){swap_r[SAMPLE_BITS-1]}}, swap_r};
        avg    = mix_avg(ext_l, ext_r);
        proc_l = swap_l;
        proc_r = swap_r;
        if (mix) begin
            proc_l = avg[SAMPLE_BITS-1:0];
            proc_r = avg[SAMPLE_BITS-1:0];
        end
        if (mute) begin
            proc_l = '0;
            proc_r = '0;
        end
    end

    // Frame sequencing and shifting. The bit counter starts at the last slot
    // so the very first BCLK fall after reset wraps it and captures a sample,
    // which guarantees a whole frame is sent from the first slot onward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt        <= '1;
            aud_daclrck   <= 1'b0;
            aud_dacdat    <= 1'b0;
            sample_strobe <= 1'b0;
            sh_l          <= '0;
            sh_r          <= '0;
        end else begin
            sample_strobe <= capture;
            if (bclk_fall) begin
                bitcnt      <= bitcnt_nxt;
                aud_daclrck <= bitcnt_nxt[BW-1];
                if (capture) begin
                    // Slot 0 of the left half: the one-BCLK I2S delay bit.
                    sh_l       <= proc_l;
                    sh_r       <= proc_r;
                    aud_dacdat <= 1'b0;
                end else if ((h_nxt != '0) && (int'(h_nxt) <= SAMPLE_BITS)) begin
                    if (bitcnt_nxt[BW-1]) begin
                        aud_dacdat <= sh_r[SAMPLE_BITS-1];
                        sh_r       <= sh_r << 1;
                    end else begin
                        aud_dacdat <= sh_l[SAMPLE_BITS-1];
                        sh_l       <= sh_l << 1;
                    end
                end else begin
                    aud_dacdat <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- Serializes 16-bit signed left/right PCM samples from the system clock domain into an I2S stream for the board audio codec (WM8731 class).
- Generates XCK, BCLK, DACLRCK and DACDAT.
- Sits downstream of the virtual toplevel's audio_l/audio_r outputs, in the codec data path next to the I2C configuration logic.
- Provides a per-frame sample strobe so the upstream mixer can present the next sample.

Parameters:
- XCK_DIV, 1, XCK half-period in clk cycles; XCK = clk/(2*XCK_DIV); legal range ≥1.
- BCLK_DIV, 4, BCLK half-period in clk cycles; BCLK = clk/(2*BCLK_DIV); legal range ≥2.
- SAMPLE_BITS, 16, sample width; legal range ≤31.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ldata  in  SAMPLE_BITS  left sample, signed two's complement.
- rdata  in  SAMPLE_BITS  right sample, signed two's complement.
- exchan  in  1  swap left/right.
- mix  in  1  centred mix: both channels carry the channel average.
- mute  in  1  force transmitted samples to zero.
- sample_strobe  out  1  one-clk pulse when ldata/rdata are captured.
- aud_xck  out  1  codec master clock.
- aud_bclk  out  1  bit clock.
- aud_daclrck  out  1  LR clock; 0 = left, 1 = right.
- aud_dacdat  out  1  serial data.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n. All flops clear immediately on rst_n low.
- Reset values:
  - aud_xck = 0, aud_bclk = 0, aud_daclrck = 0, aud_dacdat = 0, sample_strobe = 0.
  - Shift registers = 0; xck counter = 0; bclk counter = 0; bit counter = 63.
- XCK: free-running counter 0..XCK_DIV-1; aud_xck toggles on terminal count. Independent of the BCLK logic.
- BCLK: counter 0..BCLK_DIV-1; aud_bclk toggles on terminal count.
  - "fall event" = the clk cycle in which aud_bclk toggles 1→0.
  - All serial state updates occur only on a fall event, so the codec samples on BCLK rising edges with BCLK_DIV clk cycles of setup.
- Bit counter (6 bits, 0..63) increments on each fall event and wraps 63→0.
  - Frame = 64 BCLK; 32 bits per channel.
  - Sample rate = clk/(128*BCLK_DIV).
- aud_daclrck = bitcnt[5], registered, updated on the same fall event as bitcnt.
- Sample capture: on the fall event where bitcnt wraps 63→0:
  - Latch processed left/right values into shift registers.
  - Pulse sample_strobe high for exactly one clk, coincident with the register update.
  - The first capture occurs on the first fall event after reset.
- Processing order, all combinational at capture time:
  1. Swap: if exchan, L' = rdata and R' = ldata; else L' = ldata and R' = rdata.
  2. Mix: if mix, both channels = (sign-extend(L') + sign-extend(R')) >>> 1. The sum is computed at SAMPLE_BITS+1 bits; take bits [SAMPLE_BITS:1]. Truncate toward −∞; no overflow is possible.
  3. Mute: if mute, both channels = 0. Mute overrides mix.
- I2S framing, one BCLK delay:
  - Within each 32-bit half, half-index h = bitcnt[4:0].
  - h = 0: aud_dacdat = 0.
  - h = 1..SAMPLE_BITS: aud_dacdat = sample bit SAMPLE_BITS−h, MSB first.
  - h > SAMPLE_BITS: aud_dacdat = 0.
  - Left is sent while daclrck = 0; right while daclrck = 1.
- Input timing: ldata/rdata/exchan/mix/mute are sampled only at capture. Changes mid-frame have no effect until the next frame.
- Reset mid-frame: outputs return to reset values asynchronously. On release the stream restarts with the first capture on the first fall event, with no partial frame emitted.
- Latency: input presented at a strobe cycle appears as its MSB at daclrck-low h = 1, i.e. 1 BCLK after capture.

Decomposition:
- Package audio_pkg:
  - FRAME_BITS = 64, HALF_BITS = 32.
  - Typedef sample_t (signed [SAMPLE_BITS-1:0]).
  - Function mix_avg(a, b).
- Sub-module audio_clk_div, instantiated twice (XCK and BCLK).
  - Parameter DIV.
  - Ports clk, rst_n, clk_out, fall (one-clk pulse on the 1→0 toggle).

Test Plan:
- Reset then free run, BCLK_DIV = 4:
  - aud_bclk period = 8 clk; aud_daclrck period = 512 clk.
  - sample_strobe every 512 clk; first strobe 8 clk after rst_n release.
- ldata = 16'hA5C3, rdata = 16'h1234:
  - Left half decodes, on BCLK rising edges at h = 1..16, to A5C3; right half decodes to 1234.
  - Bits h = 0 and h = 17..31 are 0.
- exchan = 1, same data: left decodes to 1234, right to A5C3.
- mix = 1, ldata = 16'h7FFF, rdata = 16'h7FFF: both channels 7FFF.
- mix = 1, ldata = 16'h8000, rdata = 16'h0001: both channels C000.
- mute = 1 with mix = 1: both channels 0000.
- Change ldata mid-frame at bitcnt = 40: the current frame is unchanged; the new value appears only after the next strobe.
- Assert rst_n low at bitcnt = 20 for 3 clk:
  - All outputs go to 0 asynchronously in the same cycle.
  - After release, the first strobe is again 8 clk later and the frame restarts at h = 0 of left.
